// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Owns the program counter and walks the word-addressed instruction memory.
//   Each fetched word is held in an output register and offered to decode
//   with a valid/ready handshake. The block handles decode backpressure,
//   branch/jump redirects (which flush the pending word), a halt opcode that
//   parks fetch until restart, and a sticky fault on misaligned targets.
//
// Ports:
//   clock            rising-edge system clock
//   reset_n          asynchronous active-low reset
//   mem_address      word address to instruction memory (pc[ADDR_WIDTH+1:2])
//   mem_instruction  word returned by memory for mem_address, same cycle
//   redirect_valid   branch/jump taken this cycle
//   redirect_pc      byte target PC of the redirect
//   out_valid        out_instruction/out_pc hold a fetched word
//   out_ready        decode accepts the word when out_valid & out_ready
//   out_instruction  fetched word
//   out_pc           byte PC of out_instruction
//   restart          leave HALT and resume fetching at the held pc
//   halted           high while in HALT
//   fault            high while in FAULT (cleared only by reset)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [31:0]           out_pc,
  input  logic                  restart,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        slot_free;
  logic        target_aligned;
  logic        halt_word;

  // Memory is addressed in words, so the two byte-offset bits are dropped.
  // Upper pc bits beyond the memory size are ignored, which makes fetch wrap.
  assign mem_address = pc[ADDR_WIDTH+1:2];

  // The output register can take a new word when it is empty or when decode
  // is draining it on this same edge.
  assign slot_free      = !out_valid || out_ready;
  assign target_aligned = (redirect_pc[1:0] == 2'b00);
  assign halt_word      = (mem_instruction[31:26] == HALT_OPCODE);

  // Single sequencing process: state, pc and the output register all move
  // together. Redirect is checked first in RUN and HALT because a taken
  // branch makes both the pending word and the current fetch stale. halted
  // and fault are written alongside every state change so they are plain
  // registered decodes of the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
      halted          <= 1'b0;
      fault           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
        end

        RUN: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (target_aligned) begin
              pc <= redirect_pc;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (slot_free) begin
            out_instruction <= mem_instruction;
            out_pc          <= pc;
            out_valid       <= 1'b1;
            pc              <= pc + 32'd4;
            // The halt word itself is still handed to decode.
            if (halt_word) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end

        HALT: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            halted    <= 1'b0;
            if (target_aligned) begin
              pc    <= redirect_pc;
              state <= RUN;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else begin
            // No new captures here, but a word already offered must still
            // complete its handshake.
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
            end
            if (restart) begin
              state  <= RUN;
              halted <= 1'b0;
            end
          end
        end

        FAULT: begin
          // Everything is frozen until reset.
          out_valid <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Purpose:
//   Self-checking bench for fetch_sequencer. A behavioural instruction memory
//   feeds the DUT, and a transaction-level reference model predicts the
//   output register, pc-derived memory address and status flags after every
//   clock edge. Directed steps cover the main scenarios, followed by a
//   randomized run with backpressure, redirects, halts and restarts.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MEM_WORDS = 1 << AW;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_instruction;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instruction;
  logic [31:0]   out_pc;
  logic          restart;
  logic          halted;
  logic          fault;

  logic [31:0] mem [0:MEM_WORDS-1];

  int checks = 0;
  int errors = 0;

  // Reference model: a fetch engine described by what it has delivered,
  // whether it has started, and whether it is parked or dead.
  bit          m_started;
  bit          m_parked;
  bit          m_dead;
  logic [31:0] m_next_pc;
  bit          m_have_word;
  logic [31:0] m_word;
  logic [31:0] m_word_pc;

  fetch_sequencer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESET_PC   (32'h0000_0000),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_address    (mem_address),
    .mem_instruction(mem_instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .restart        (restart),
    .halted         (halted),
    .fault          (fault)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Combinational memory: the word is available in the same cycle.
  assign mem_instruction = mem[mem_address];

  // One comparison: counts the check and reports any difference.
  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compares every observable output against the reference model.
  task automatic checkOutput(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_have_word});
    chk({tag, ".out_instruction"}, out_instruction, m_word);
    chk({tag, ".out_pc"}, out_pc, m_word_pc);
    chk({tag, ".mem_address"}, {22'd0, mem_address}, (m_next_pc >> 2) % MEM_WORDS);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_parked});
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, m_dead});
  endtask

  task automatic modelReset();
    m_started   = 0;
    m_parked    = 0;
    m_dead      = 0;
    m_next_pc   = 32'h0000_0000;
    m_have_word = 0;
    m_word      = '0;
    m_word_pc   = '0;
  endtask

  // Predicts the effect of one clock edge given the inputs held across it.
  task automatic modelStep(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rs);
    logic [31:0] w;
    if (!m_started) begin
      m_started = 1;
    end else if (m_dead) begin
      // nothing moves
    end else if (rv) begin
      m_have_word = 0;
      m_parked    = 0;
      if (rpc % 4 == 0) m_next_pc = rpc;
      else m_dead = 1;
    end else if (m_parked) begin
      if (m_have_word && rdy) m_have_word = 0;
      if (rs) m_parked = 0;
    end else if (!m_have_word || rdy) begin
      w = mem[(m_next_pc / 4) % MEM_WORDS];
      m_word      = w;
      m_word_pc   = m_next_pc;
      m_have_word = 1;
      m_next_pc   = m_next_pc + 32'd4;
      if (w[31:26] == 6'b111111) m_parked = 1;
    end
  endtask

  // Drives one cycle of inputs, advances the model, and checks after the edge.
  task automatic applyStimulus(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rs,
                               input string tag);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    restart        = rs;
    modelStep(rdy, rv, rpc, rs);
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  // Asserts reset asynchronously away from any edge, checks the reset
  // values immediately, then releases on a falling edge.
  task automatic applyReset(input string tag);
    #3;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    reset_n        = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    restart        = 1'b0;

    // Random program with no halt words, then one planted halt at word 5.
    for (int i = 0; i < MEM_WORDS; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31] = 1'b0;
      mem[i] = w;
    end
    mem[5] = 32'hFC00_0000;

    modelReset();
    #2;
    checkOutput("reset");
    chk("reset.out_pc_zero", out_pc, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Startup: one idle edge, then words 0..3 back to back.
    applyStimulus(1, 0, 0, 0, "idle_edge");
    chk("first_edge_no_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1, 0, 0, 0, "word0");
    chk("word0_pc", out_pc, 32'h0);
    chk("word0_data", out_instruction, mem[0]);
    for (int i = 1; i < 4; i++) applyStimulus(1, 0, 0, 0, "stream");
    chk("word3_pc", out_pc, 32'hC);

    // Go back to word 1 and stall on it for three cycles.
    applyStimulus(1, 1, 32'h4, 0, "redir_4");
    applyStimulus(1, 0, 0, 0, "wordB");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, "stall");
    chk("stall_pc", out_pc, 32'h4);
    chk("stall_addr", {22'd0, mem_address}, 32'd2);

    // Redirect while stalled flushes B; word 16 arrives one cycle later.
    applyStimulus(0, 1, 32'h40, 0, "redir_stalled");
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1, 0, 0, 0, "word16");
    chk("word16_pc", out_pc, 32'h40);

    // Accept plus redirect together, then run into the halt word.
    applyStimulus(1, 1, 32'h10, 0, "redir_accept");
    applyStimulus(1, 0, 0, 0, "word4");
    applyStimulus(1, 0, 0, 0, "halt_word");
    chk("halt_pc", out_pc, 32'h14);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "halted");
    applyStimulus(1, 0, 0, 1, "restart");
    applyStimulus(1, 0, 0, 0, "resume");
    chk("resume_pc", out_pc, 32'h18);

    // Top of memory and wrap back to word 0.
    applyStimulus(1, 1, 32'hFFC, 0, "redir_top");
    applyStimulus(1, 0, 0, 0, "word1023");
    chk("top_pc", out_pc, 32'hFFC);
    chk("wrap_addr", {22'd0, mem_address}, 32'd0);
    applyStimulus(1, 0, 0, 0, "wrap");
    chk("wrap_pc", out_pc, 32'h1000);

    // Randomized phase with some halt words scattered through memory.
    for (int i = 0; i < 24; i++) begin
      mem[$urandom_range(0, MEM_WORDS - 1)] = {6'b111111, 26'($urandom)};
    end
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 16) == 0,
                    $urandom & 32'hFFFF_FFFC, ($urandom % 6) == 0, "random");
    end

    // Reset in the middle of a stall.
    applyStimulus(0, 0, 0, 0, "pre_reset_stall");
    applyReset("reset_mid_stall");
    applyStimulus(1, 0, 0, 0, "idle_again");
    applyStimulus(0, 0, 0, 0, "capture_again");

    // Misaligned target faults; later redirect/restart are ignored.
    applyStimulus(0, 1, 32'h42, 0, "misaligned");
    chk("fault_flag", {31'd0, fault}, 32'd1);
    chk("fault_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1, 1, 32'h80, 0, "fault_redir");
    applyStimulus(1, 0, 0, 1, "fault_restart");
    applyStimulus(1, 0, 0, 0, "fault_hold");
    applyReset("reset_from_fault");
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    applyStimulus(1, 0, 0, 0, "post_fault_idle");
    applyStimulus(1, 0, 0, 0, "post_fault_word0");
    chk("post_fault_pc", out_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the word-addressed instruction memory. Owns the program counter and drives the memory read address. Captures each fetched word into an output register with a valid/ready handshake toward decode. Handles backpressure stalls, branch/jump redirects with flush, a halt opcode, and misaligned-target faults.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 10, instruction memory word-address width
RESET_PC, 32'h0000_0000, byte PC loaded on reset
HALT_OPCODE, 6'b111111, value of instr[31:26] that halts fetch

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_address  out  ADDR_WIDTH  word address to instruction memory = pc[ADDR_WIDTH+1:2], combinational from pc register
mem_instruction  in  DATA_WIDTH  word returned by memory, treated as valid in the same cycle as mem_address
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  byte target PC for redirect
out_valid  out  1  out_instruction/out_pc hold a fetched word
out_ready  in  1  decode accepts the word when out_valid & out_ready
out_instruction  out  DATA_WIDTH  fetched word
out_pc  out  32  byte PC of out_instruction
restart  in  1  leave HALT and resume fetching
halted  out  1  high in HALT state
fault  out  1  high in FAULT state

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=RESET_PC, out_valid=0, out_instruction=0, out_pc=0, halted=0, fault=0.
- States: IDLE, RUN, HALT, FAULT, encoded in 2 bits.
- IDLE: first rising edge after reset_n deasserts -> RUN. No capture. Redirect is ignored in IDLE.
- RUN: slot_free = !out_valid | out_ready.
- RUN, slot_free and no redirect: out_instruction<=mem_instruction, out_pc<=pc, out_valid<=1, pc<=pc+4.
- RUN, !slot_free (stall): pc, out_instruction, out_pc and out_valid all hold.
- Captured word with mem_instruction[31:26]==HALT_OPCODE: the word is still delivered and pc<=pc+4. State -> HALT on the same edge.
- Redirect has priority over capture in RUN and HALT.
- Redirect with aligned target (redirect_pc[1:0]==0): pc<=redirect_pc, out_valid<=0 (flush, even when stalled), state -> RUN. The first word from the target is captured on the following edge, so redirect-to-valid latency is 2 cycles.
- Redirect with misaligned target: state -> FAULT, out_valid<=0, pc unchanged.
- HALT: no captures and pc holds. out_valid keeps its handshake: it clears when the pending word is accepted.
- HALT exits: restart=1 -> RUN, fetching resumes at the held pc. An aligned redirect in HALT behaves as in RUN.
- Simultaneous restart and redirect: redirect wins.
- FAULT: outputs frozen with out_valid=0. redirect and restart are ignored. Exit only via reset.
- Arithmetic: pc+4 is modulo 2^32. mem_address uses pc[ADDR_WIDTH+1:2], so fetch wraps to word 0 after byte address 4*2^ADDR_WIDTH-4.
- Accepted word plus redirect in the same cycle: the consumer's accept counts as done, and out_valid is 0 next cycle.
- Reset asserted mid-stall or mid-redirect returns immediately to the reset values above.
- halted = (state==HALT); fault = (state==FAULT); both are registered state decodes.

Test Plan:
- Reset then out_ready=1, memory words 0..3 = A,B,C,D -> out_valid first high on the 2nd edge after reset release, then out_pc=0,4,8,12 with A,B,C,D on consecutive cycles.
- Hold out_ready=0 for 3 cycles with word B pending -> out_instruction=B, out_pc=4 and mem_address=2 stable. After release, C follows with out_pc=8.
- Redirect to 0x40 while stalled on B -> next cycle out_valid=0. The following cycle delivers word 16 with out_pc=0x40; B is never accepted.
- Word 5 = 0xFC00_0000 -> it is delivered with out_pc=0x14, halted=1, and no further words appear. restart -> the next word has out_pc=0x18.
- Redirect to 0x42 -> fault=1, out_valid=0. Later redirects and restart are ignored. reset_n low clears fault=0 with pc=RESET_PC.
- Redirect to 0xFFC with ADDR_WIDTH=10 -> word 1023 at out_pc=0xFFC, then out_pc=0x1000 with mem_address=0 (wrap).
